// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package data_mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } arb_state_e;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_DBG  = 1'b1;

   localparam int DEF_AW = 8;
   localparam int DEF_DW = 8;

endpackage

// File: rtl/data_mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker with a single-cycle hold override.
module rr_pick2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   input  logic       hold_i,
   input  logic       hold_idx_i,
   output logic       gnt_valid_o,
   output logic       gnt_idx_o
);

   // Hold wins only while the held port still requests; otherwise alternate on a tie.
   always_comb begin
      gnt_valid_o = |req_i;
      gnt_idx_o   = 1'b0;
      if (hold_i && req_i[hold_idx_i]) begin
         gnt_idx_o = hold_idx_i;
      end else if (req_i == 2'b11) begin
         gnt_idx_o = ~last_i;
      end else if (req_i[1]) begin
         gnt_idx_o = 1'b1;
      end else begin
         gnt_idx_o = 1'b0;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between the core LSU (port 0) and the debug loader (port 1).
module data_mem_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int AW       = DEF_AW,
   parameter int DW       = DEF_DW,
   parameter int MAX_LOCK = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m0_lock,
   output logic          m0_ack,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   input  logic          m1_lock,
   output logic          m1_ack,
   output logic [DW-1:0] m1_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_a,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd,
   output logic          busy,
   output logic          last_grant
);

   localparam logic [3:0] LOCK_LIM = 4'(MAX_LOCK - 1);

   arb_state_e    state_q;
   logic          gnt_q;
   logic          hold_q;
   logic [3:0]    lock_cnt_q;
   logic          m0_ack_q, m1_ack_q;
   logic [DW-1:0] m0_rdata_q, m1_rdata_q;
   logic          mem_we_q;
   logic [AW-1:0] mem_a_q;
   logic [DW-1:0] mem_wd_q;
   logic          busy_q;
   logic          last_grant_q;

   logic [1:0]    req_s;
   logic          gnt_valid_s, gnt_idx_s;
   logic          sel_we_s;
   logic [AW-1:0] sel_addr_s;
   logic [DW-1:0] sel_wdata_s;
   logic          lock_ok_s;
   logic          hold_d, keep_cnt_s;
   logic [3:0]    lock_cnt_d;

   assign req_s = {m1_req, m0_req};

   rr_pick2 u_pick (
      .req_i      (req_s),
      .last_i     (last_grant_q),
      .hold_i     (hold_q),
      .hold_idx_i (gnt_q),
      .gnt_valid_o(gnt_valid_s),
      .gnt_idx_o  (gnt_idx_s)
   );

   // Request mux for the IDLE winner and lock decision for the port finishing in RESP.
   always_comb begin
      sel_we_s    = gnt_idx_s ? m1_we    : m0_we;
      sel_addr_s  = gnt_idx_s ? m1_addr  : m0_addr;
      sel_wdata_s = gnt_idx_s ? m1_wdata : m0_wdata;
      lock_ok_s   = (gnt_q ? m1_lock : m0_lock) && (lock_cnt_q < LOCK_LIM);
      keep_cnt_s  = hold_q && req_s[gnt_q];
      if (lock_ok_s) begin
         hold_d     = 1'b1;
         lock_cnt_d = lock_cnt_q + 4'd1;
      end else begin
         hold_d     = 1'b0;
         lock_cnt_d = 4'd0;
      end
   end

   // Access FSM with registered memory strobes, acks and read-data capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         gnt_q        <= PORT_DBG;
         hold_q       <= 1'b0;
         lock_cnt_q   <= 4'd0;
         m0_ack_q     <= 1'b0;
         m1_ack_q     <= 1'b0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_a_q      <= '0;
         mem_wd_q     <= '0;
         busy_q       <= 1'b0;
         last_grant_q <= PORT_DBG;
      end else begin
         m0_ack_q <= 1'b0;
         m1_ack_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // The hold is a one-shot: it is spent (or dropped) in this cycle either way.
               hold_q <= 1'b0;
               if (!keep_cnt_s) begin
                  lock_cnt_q <= 4'd0;
               end
               if (gnt_valid_s) begin
                  state_q  <= ST_ACCESS;
                  gnt_q    <= gnt_idx_s;
                  mem_we_q <= sel_we_s;
                  mem_a_q  <= sel_addr_s;
                  mem_wd_q <= sel_wdata_s;
                  busy_q   <= 1'b1;
               end
            end
            ST_ACCESS: begin
               state_q      <= ST_RESP;
               mem_we_q     <= 1'b0;
               mem_a_q      <= '0;
               mem_wd_q     <= '0;
               last_grant_q <= gnt_q;
               if (gnt_q) begin
                  m1_rdata_q <= mem_rd;
                  m1_ack_q   <= 1'b1;
               end else begin
                  m0_rdata_q <= mem_rd;
                  m0_ack_q   <= 1'b1;
               end
            end
            ST_RESP: begin
               state_q    <= ST_IDLE;
               busy_q     <= 1'b0;
               hold_q     <= hold_d;
               lock_cnt_q <= lock_cnt_d;
            end
            default: begin
               state_q  <= ST_IDLE;
               mem_we_q <= 1'b0;
               mem_a_q  <= '0;
               mem_wd_q <= '0;
               busy_q   <= 1'b0;
               hold_q   <= 1'b0;
            end
         endcase
      end
   end

   assign m0_ack     = m0_ack_q;
   assign m1_ack     = m1_ack_q;
   assign m0_rdata   = m0_rdata_q;
   assign m1_rdata   = m1_rdata_q;
   assign mem_we     = mem_we_q;
   assign mem_a      = mem_a_q;
   assign mem_wd     = mem_wd_q;
   assign busy       = busy_q;
   assign last_grant = last_grant_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed scoreboard bench for data_mem_arbiter with a behavioural 256x8 memory (address 0 reads zero).
module tb_data_mem_arbiter;

   logic       clk, rst;
   logic       m0_req, m0_we, m0_lock, m0_ack;
   logic [7:0] m0_addr, m0_wdata, m0_rdata;
   logic       m1_req, m1_we, m1_lock, m1_ack;
   logic [7:0] m1_addr, m1_wdata, m1_rdata;
   logic       mem_we, busy, last_grant;
   logic [7:0] mem_a, mem_wd, mem_rd;

   logic [7:0] mem [256];

   typedef struct {
      logic       port;
      logic [7:0] rdata;
   } exp_t;
   exp_t sb_q[$];

   int total = 0;
   int passed = 0;
   int cyc = 0;
   int ack_cyc [2];
   int lg_at_ack [2];

   data_mem_arbiter #(.AW(8), .DW(8), .MAX_LOCK(4)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_lock(m0_lock), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
      .busy(busy), .last_grant(last_grant)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: synchronous write, combinational read, address 0 hard-wired to zero.
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   end
   always @(posedge clk) if (mem_we && mem_a != 8'h00) mem[mem_a] <= mem_wd;
   assign mem_rd = (mem_a == 8'h00) ? 8'h00 : mem[mem_a];

   m0_hold_req: assert property (@(posedge clk) disable iff (!rst) (m0_req && !m0_ack) |=> m0_req)
      else $error("port 0 dropped req before ack");
   m1_hold_req: assert property (@(posedge clk) disable iff (!rst) (m1_req && !m1_ack) |=> m1_req)
      else $error("port 1 dropped req before ack");

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic push(input logic p, input logic [7:0] d);
      exp_t e;
      e.port  = p;
      e.rdata = d;
      sb_q.push_back(e);
   endtask

   // Monitor: every ack pops the next expected response.
   always @(negedge clk) begin
      logic p_v;
      exp_t e_v;
      if (rst && (m0_ack || m1_ack)) begin
         if (m0_ack && m1_ack) chk("dual_ack", 32'd1, 32'd0);
         p_v = m1_ack;
         ack_cyc[p_v]   = cyc;
         lg_at_ack[p_v] = int'(last_grant);
         if (sb_q.size() == 0) begin
            chk("unexpected_ack_port", 32'(p_v), 32'hFFFF);
         end else begin
            e_v = sb_q.pop_front();
            chk("ack_port", 32'(p_v), 32'(e_v.port));
            chk("rdata", 32'(p_v ? m1_rdata : m0_rdata), 32'(e_v.rdata));
         end
      end
   end

   task automatic drive(input logic p, input logic we, input logic [7:0] a,
                        input logic [7:0] d, input logic lk);
      if (p) begin
         m1_we = we; m1_addr = a; m1_wdata = d; m1_lock = lk; m1_req = 1'b1;
      end else begin
         m0_we = we; m0_addr = a; m0_wdata = d; m0_lock = lk; m0_req = 1'b1;
      end
   endtask

   // One transaction: request at a negedge, wait for ack, release in the following IDLE cycle.
   task automatic txn(input logic p, input logic we, input logic [7:0] a,
                      input logic [7:0] d, input logic lk);
      bit got = 1'b0;
      drive(p, we, a, d, lk);
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (p ? m1_ack : m0_ack) got = 1'b1;
      end
      if (!got) begin
         total++;
         $display("FAIL txn_timeout port %0d: no ack within 40 cycles, ack required", p);
      end else begin
         @(negedge clk);
      end
      if (p) m1_req = 1'b0;
      else   m0_req = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"},   32'(busy),       32'd0);
      chk({tag, "_mem_we"}, 32'(mem_we),     32'd0);
      chk({tag, "_mem_a"},  32'(mem_a),      32'd0);
      chk({tag, "_mem_wd"}, 32'(mem_wd),     32'd0);
      chk({tag, "_lastg"},  32'(last_grant), 32'd1);
      chk({tag, "_acks"},   32'({m1_ack, m0_ack}), 32'd0);
      chk({tag, "_rdata0"}, 32'(m0_rdata),   32'd0);
      chk({tag, "_rdata1"}, 32'(m1_rdata),   32'd0);
   endtask

   initial begin
      bit seen;
      rst = 1'b0;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = 8'h00; m0_wdata = 8'h00; m0_lock = 1'b0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = 8'h00; m1_wdata = 8'h00; m1_lock = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b1;
      @(negedge clk);

      // Simultaneous requests after reset: port 0 first, then port 1 sees port 0's write.
      push(1'b0, 8'h00);
      push(1'b1, 8'h55);
      lg_at_ack[0] = -1; lg_at_ack[1] = -1;
      fork
         txn(1'b0, 1'b1, 8'h30, 8'h55, 1'b0);
         txn(1'b1, 1'b0, 8'h30, 8'h00, 1'b0);
      join
      chk("tie_ack_spacing", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
      chk("tie_lastg_first", 32'(lg_at_ack[0]), 32'd0);
      chk("tie_lastg_second", 32'(lg_at_ack[1]), 32'd1);

      // Port 0 write with cycle-exact strobe checks, then read-back.
      push(1'b0, 8'h00);
      drive(1'b0, 1'b1, 8'h10, 8'hA5, 1'b0);
      @(negedge clk);
      chk("wr_access_we", 32'(mem_we), 32'd1);
      chk("wr_access_a", 32'(mem_a), 32'h10);
      chk("wr_access_wd", 32'(mem_wd), 32'hA5);
      chk("wr_access_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("wr_resp_we", 32'(mem_we), 32'd0);
      chk("wr_resp_ack", 32'(m0_ack), 32'd1);
      chk("wr_resp_a", 32'(mem_a), 32'd0);
      @(negedge clk);
      chk("wr_idle_busy", 32'(busy), 32'd0);
      m0_req = 1'b0;
      push(1'b0, 8'hA5);
      txn(1'b0, 1'b0, 8'h10, 8'h00, 1'b0);

      // Address 0 ignores writes.
      push(1'b1, 8'h00);
      txn(1'b1, 1'b1, 8'h00, 8'h3C, 1'b0);
      push(1'b1, 8'h00);
      txn(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

      // Locked burst: four port-0 grants, then port 1, then port 0 again.
      for (int i = 0; i < 4; i++) push(1'b0, 8'hA5);
      push(1'b1, 8'h00);
      push(1'b0, 8'hA5);
      fork
         begin
            for (int i = 0; i < 5; i++) txn(1'b0, 1'b0, 8'h10, 8'h00, 1'b1);
         end
         txn(1'b1, 1'b1, 8'h11, 8'h77, 1'b0);
      join

      // Port 1 raises req during port 0's RESP cycle.
      push(1'b0, 8'h77);
      push(1'b1, 8'h77);
      fork
         txn(1'b0, 1'b0, 8'h11, 8'h00, 1'b0);
         begin
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
               @(negedge clk);
               if (m0_ack) seen = 1'b1;
            end
            if (seen) txn(1'b1, 1'b0, 8'h11, 8'h00, 1'b0);
            else chk("late_req_m0_ack_seen", 32'd0, 32'd1);
         end
      join
      chk("late_req_spacing", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);

      // Reset during ACCESS of a write aborts it.
      drive(1'b0, 1'b1, 8'h20, 8'hFF, 1'b0);
      @(negedge clk);
      chk("abort_access_we", 32'(mem_we), 32'd1);
      rst = 1'b0;
      m0_req = 1'b0;
      #1;
      chk_reset_outputs("abort");
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      push(1'b0, 8'h00);
      txn(1'b0, 1'b0, 8'h20, 8'h00, 1'b0);
      push(1'b1, 8'h77);
      txn(1'b1, 1'b0, 8'h11, 8'h00, 1'b0);

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
